// File: rtl/psx_poll_master_if.sv
// rtl/psx_poll_master_if.sv - request/status and controller-pin bundle for psx_poll_master
// Purpose: groups the frame request, the result status and the controller connector
//   pins so the poll master and its user share one connection.
// Signals: start/tx_payload (frame request), busy/done/timeout/bad_id/rx_data/rx_count
//   (frame status), psx_clk/cmd/att (to controller), data/ack_n (from controller).
// Modports: master = poll master side, slave = requester plus controller side.
interface psx_poll_master_if #(
  parameter int NUM_BYTES = 5
);
  logic                        start;
  logic [8*(NUM_BYTES-2)-1:0]  tx_payload;
  logic                        data;
  logic                        ack_n;
  logic                        psx_clk;
  logic                        cmd;
  logic                        att;
  logic                        busy;
  logic                        done;
  logic                        timeout;
  logic                        bad_id;
  logic [8*NUM_BYTES-1:0]      rx_data;
  logic [7:0]                  rx_count;

  modport master (
    input  start, tx_payload, data, ack_n,
    output psx_clk, cmd, att, busy, done, timeout, bad_id, rx_data, rx_count
  );

  modport slave (
    output start, tx_payload, data, ack_n,
    input  psx_clk, cmd, att, busy, done, timeout, bad_id, rx_data, rx_count
  );
endinterface

// File: rtl/psx_poll_master.sv
// rtl/psx_poll_master.sv - PlayStation controller poll-frame bus master
// Purpose: on an accepted start, lowers ATT, shifts NUM_BYTES bytes out on CMD
//   (0x01, 0x42, then tx_payload bytes, LSB first) while capturing DATA, waits for
//   ACK between bytes with a timeout, raises ATT and reports the frame result.
// Ports: clk - system clock (rising edge); rst - asynchronous active-high reset;
//   bus - psx_poll_master_if.master: start/tx_payload in, data/ack_n from the
//   controller, psx_clk/cmd/att to the controller, busy/done/timeout/bad_id/
//   rx_data/rx_count status out (status changes only on done).
module psx_poll_master #(
  parameter int NUM_BYTES   = 5,
  parameter int HALF_BIT    = 4,
  parameter int ATT_SETUP   = 20,
  parameter int ACK_TIMEOUT = 200,
  parameter int BYTE_GAP    = 4,
  parameter int ATT_HOLD    = 8
) (
  input  logic              clk,
  input  logic              rst,
  psx_poll_master_if.master bus
);
  localparam int PW = 8*(NUM_BYTES-2);
  localparam int RW = 8*NUM_BYTES;

  localparam logic [15:0] SETUP_LAST = 16'(ATT_SETUP-1);
  localparam logic [15:0] HALF_LAST  = 16'(HALF_BIT-1);
  localparam logic [15:0] ACK_LAST   = 16'(ACK_TIMEOUT-1);
  localparam logic [15:0] GAP_LAST   = 16'(BYTE_GAP-1);
  localparam logic [15:0] HOLD_LAST  = 16'(ATT_HOLD-1);
  localparam logic [7:0]  LAST_BYTE  = 8'(NUM_BYTES-1);

  typedef enum logic [2:0] {
    IDLE, SETUP, BIT_LOW, BIT_HIGH, ACK_WAIT, GAP, HOLD, FINISH
  } state_t;

  state_t        state;
  logic [15:0]   cnt;
  logic [7:0]    byte_idx;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic [PW-1:0] payload_q;
  logic [RW-1:0] rx_stage;
  logic [7:0]    count_stage;
  logic          timeout_stage;
  logic          ack_meta;
  logic          ack_sync;
  logic          ack_seen;
  logic [PW-1:0] payload_shifted;
  logic [7:0]    tx_byte;

  // ack_n is driven by the controller with no relation to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta <= 1'b1;
      ack_sync <= 1'b1;
    end else begin
      ack_meta <= bus.ack_n;
      ack_sync <= ack_meta;
    end
  end

  assign ack_seen = ~ack_sync;

  // Byte currently on CMD. byte_idx advances on ack, so during GAP this is
  // already the next byte and its bit 0 is ready for the first clock fall.
  always_comb begin
    payload_shifted = payload_q >> {byte_idx - 8'd2, 3'b000};
    if (byte_idx == 8'd0)      tx_byte = 8'h01;
    else if (byte_idx == 8'd1) tx_byte = 8'h42;
    else                       tx_byte = payload_shifted[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      byte_idx      <= '0;
      bit_idx       <= '0;
      rx_shift      <= '0;
      payload_q     <= '0;
      rx_stage      <= '0;
      count_stage   <= '0;
      timeout_stage <= 1'b0;
      bus.psx_clk   <= 1'b1;
      bus.cmd       <= 1'b1;
      bus.att       <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.bad_id    <= 1'b0;
      bus.rx_data   <= '0;
      bus.rx_count  <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle is spent in IDLE; a start landing on it is dropped.
          if (bus.start && !bus.done) begin
            payload_q     <= bus.tx_payload;
            byte_idx      <= '0;
            bit_idx       <= '0;
            rx_shift      <= '0;
            rx_stage      <= '0;
            count_stage   <= '0;
            timeout_stage <= 1'b0;
            cnt           <= '0;
            bus.att       <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt         <= '0;
            bus.psx_clk <= 1'b0;
            bus.cmd     <= tx_byte[0];
            state       <= BIT_LOW;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BIT_LOW: begin
          if (cnt == HALF_LAST) begin
            cnt               <= '0;
            bus.psx_clk       <= 1'b1;
            rx_shift[bit_idx] <= bus.data;
            state             <= BIT_HIGH;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BIT_HIGH: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (bit_idx != 3'd7) begin
              bit_idx     <= bit_idx + 3'd1;
              bus.psx_clk <= 1'b0;
              bus.cmd     <= tx_byte[bit_idx + 3'd1];
              state       <= BIT_LOW;
            end else begin
              bus.cmd <= 1'b1;
              for (int k = 0; k < NUM_BYTES; k++) begin
                if (byte_idx == 8'(k)) rx_stage[8*k +: 8] <= rx_shift;
              end
              count_stage <= byte_idx + 8'd1;
              state       <= (byte_idx == LAST_BYTE) ? HOLD : ACK_WAIT;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ACK_WAIT: begin
          // Level-sensitive: an ack already low on entry is accepted at once.
          if (ack_seen) begin
            cnt      <= '0;
            byte_idx <= byte_idx + 8'd1;
            bit_idx  <= '0;
            state    <= GAP;
          end else if (cnt == ACK_LAST) begin
            cnt           <= '0;
            timeout_stage <= 1'b1;
            state         <= HOLD;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt         <= '0;
            bus.psx_clk <= 1'b0;
            bus.cmd     <= tx_byte[0];
            state       <= BIT_LOW;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= FINISH;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        FINISH: begin
          bus.att      <= 1'b1;
          bus.busy     <= 1'b0;
          bus.done     <= 1'b1;
          bus.timeout  <= timeout_stage;
          bus.rx_data  <= rx_stage;
          bus.rx_count <= count_stage;
          bus.bad_id   <= (count_stage >= 8'd3) && (rx_stage[23:16] != 8'h5A);
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/psx_poll_master.md
Name: psx_poll_master

Overview:
- Parametrised host-side PlayStation controller bus master. Successor to the single-command ATT/CLK bring-up block.
- Runs a complete poll frame:
  - lowers ATT;
  - shifts NUM_BYTES bytes out on CMD, LSB first, while capturing DATA;
  - waits for controller ACK between bytes, with timeout;
  - raises ATT and reports results.
- Sits between the controller connector pins and the input-decoding logic. Frame timing is set by parameters so the same block serves any system clock.

Parameters:
- NUM_BYTES, 5, total bytes per frame (min 3). Byte0=0x01, byte1=0x42, bytes 2..N-1 from tx_payload.
- HALF_BIT, 4, clk cycles per psx_clk low phase and per high phase.
- ATT_SETUP, 20, cycles from ATT falling to first psx_clk fall.
- ACK_TIMEOUT, 200, max cycles to wait for ack after a byte (not after the last byte).
- BYTE_GAP, 4, cycles from ack detection to next byte's first psx_clk fall.
- ATT_HOLD, 8, cycles after last bit before ATT rises.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle frame request; ignored while busy=1.
- tx_payload  input  8*(NUM_BYTES-2)  bytes 2..N-1; byte k at bits [8*(k-2)+:8]; latched on accepted start.
- data  input  1  controller DATA line.
- ack_n  input  1  controller ACK line, active low, asynchronous.
- psx_clk  output  1  bus clock, idles high.
- cmd  output  1  bus command line, idles high.
- att  output  1  attention, active low, idles high.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at frame end.
- timeout  output  1  valid with done: ack missing after some byte.
- bad_id  output  1  valid with done: received byte2 != 0x5A.
- rx_data  output  8*NUM_BYTES  received bytes; byte k at [8*k+:8]; updated only at done.
- rx_count  output  8  bytes fully received in the last frame; valid with done.

Behaviour:
- Reset (async, immediate):
  - psx_clk=1, cmd=1, att=1;
  - busy=0, done=0, timeout=0, bad_id=0;
  - rx_data=0, rx_count=0; FSM to IDLE.
  - Reset mid-frame aborts with no done pulse.
- ack_n passes through a 2-flop synchroniser. ack_seen = synced value low.
- FSM states: IDLE, SETUP, BIT_LOW, BIT_HIGH, ACK_WAIT, GAP, HOLD, FINISH.
- IDLE:
  - start=1 latches tx_payload, clears byte index, bit index and shift register.
  - att=0 and busy=1 on the next cycle -> SETUP.
- SETUP: ATT_SETUP cycles -> BIT_LOW.
- BIT_LOW:
  - psx_clk=0; cmd = current tx bit (bit index 0..7, LSB first), held HALF_BIT cycles.
  - At the edge where psx_clk returns to 1, data is sampled into bit [bit index] of the rx shift register.
- BIT_HIGH:
  - psx_clk=1 for HALF_BIT cycles.
  - If bit index < 7: bit index+1 -> BIT_LOW.
  - If bit index = 7: cmd=1, the byte is stored into rx_data staging, rx_count staging = byte index+1, then:
    - last byte -> HOLD;
    - otherwise -> ACK_WAIT.
- Bit period = 2*HALF_BIT cycles. Byte = 16*HALF_BIT cycles.
- ACK_WAIT:
  - Counter starts at 0. ack_seen -> GAP.
  - Counter reaches ACK_TIMEOUT without ack_seen -> timeout flag set -> HOLD.
  - An ack_seen already asserted on entry counts (no edge required).
- GAP: BYTE_GAP cycles, then byte index+1, bit index=0 -> BIT_LOW.
- HOLD: ATT_HOLD cycles with psx_clk=1, cmd=1 -> FINISH.
- FINISH:
  - att=1, busy=0, done=1 for one cycle.
  - Staging copied to rx_data and rx_count.
  - bad_id=1 if rx_count>=3 and byte2 != 0x5A.
  - Next cycle -> IDLE.
- Status outputs hold until the next done.
- Frame with no timeout, all zero gaps: latency from start to done = 1 + ATT_SETUP + NUM_BYTES*16*HALF_BIT + (NUM_BYTES-1)*(ack delay + BYTE_GAP) + ATT_HOLD + 1 cycles.
- start asserted in the same cycle as done: ignored. A new start is accepted only in IDLE.
- Counters are 16 bits wide, sized to parameter maxima; no wrap occurs within legal parameters.

Test Plan (NUM_BYTES=5, HALF_BIT=2, ATT_SETUP=4, ACK_TIMEOUT=20, BYTE_GAP=3, ATT_HOLD=2):
- Reset asserted mid-byte2 -> psx_clk=1, cmd=1, att=1, busy=0 immediately. No done pulse. Next start runs a clean frame.
- Nominal poll:
  - Stimulus: tx_payload=0x0000_00; model returns 0xFF,0x41,0x5A,0xFE,0xFF LSB-first; ack_n pulses low 5 cycles after each of bytes 0-3.
  - Required: CMD waveform decodes 0x01,0x42,0x00,0x00,0x00.
  - Required: rx_data=0xFF_FE_5A_41_FF, rx_count=5, timeout=0, bad_id=0, one done pulse.
- No ack after byte1 -> ACK_WAIT lasts exactly 20 cycles, then HOLD. done with timeout=1, rx_count=2, att high 3 cycles later.
- Model returns 0x00 as byte2 -> done with bad_id=1, timeout=0.
- start pulsed while busy, and again on the done cycle -> both ignored. Exactly one frame runs; busy low afterwards.
- Timing check:
  - Each psx_clk low and high phase is exactly 2 cycles.
  - ATT falls 4 cycles before the first psx_clk fall.
  - 3 cycles separate synced ack detection and the next psx_clk fall.
